// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bus bundle: I-cache request/response, execute redirect and decode-side FIFO head.
// The master modport is the fetch unit, the slave modport is its environment.
interface fetch_queue_unit_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
);
    logic [ADDR_WIDTH-1:0]    entry;
    logic                     ic_req_valid;
    logic [ADDR_WIDTH-1:0]    ic_req_addr;
    logic                     ic_req_ready;
    logic                     ic_resp_valid;
    logic [INSTR_WIDTH-1:0]   ic_resp_data;
    logic                     EXIF_branch;
    logic [ADDR_WIDTH-1:0]    EXIF_targetpc;
    logic                     dec_valid;
    logic                     dec_ready;
    logic [INSTR_WIDTH-1:0]   dec_instr;
    logic [ADDR_WIDTH-1:0]    dec_pc;
    logic [ADDR_WIDTH-1:0]    IFID_npc;
    logic                     halted;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        input  entry,
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        input  EXIF_branch, EXIF_targetpc,
        output dec_valid,
        input  dec_ready,
        output dec_instr, dec_pc, IFID_npc, halted, occupancy
    );

    modport slave (
        output entry,
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        output EXIF_branch, EXIF_targetpc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr, dec_pc, IFID_npc, halted, occupancy
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch unit with one outstanding I-cache request, epoch-tagged redirects and a DEPTH-entry decode FIFO.
// Define FETCH_HALT_ON_ZERO_EN to stop fetching on the all-zero word instead of queuing it.
module fetch_queue_unit #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int PC_STEP     = 4
) (
    input logic                clk,
    input logic                reset,
    fetch_queue_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
    localparam logic [CNT_W-1:0]      FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                    epoch_q, epoch_d;
    logic                    req_epoch_q, req_epoch_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0]   pc_mem_q    [DEPTH];
    logic [INSTR_WIDTH-1:0]  instr_mem_q [DEPTH];

    logic redirect, head_valid, req_fire, resp_ok, halt_hit, push, pop;

    assign redirect   = bus.EXIF_branch;
    assign head_valid = (count_q != '0);
    assign req_fire   = bus.ic_req_valid && bus.ic_req_ready;
    assign resp_ok    = (state_q == S_WAIT) && bus.ic_resp_valid
                        && (req_epoch_q == epoch_q) && !redirect;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign halt_hit = resp_ok && (bus.ic_resp_data == '0);
`else
    assign halt_hit = 1'b0;
`endif

    assign push = resp_ok && !halt_hit;
    assign pop  = head_valid && bus.dec_ready && !redirect;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        epoch_d     = epoch_q;
        req_epoch_d = req_epoch_q;
        if (redirect) begin
            fetch_pc_d = {bus.EXIF_targetpc[ADDR_WIDTH-1:2], 2'b00};
            epoch_d    = ~epoch_q;
            state_d    = (state_q == S_WAIT && !bus.ic_resp_valid) ? S_WAIT : S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        req_epoch_d = epoch_q;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.ic_resp_valid) begin
                        state_d = halt_hit ? S_HALT : S_REQ;
                        if (push) fetch_pc_d = fetch_pc_q + STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= bus.entry;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; an entry is only visible while the count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.ic_resp_data;
        end
    end

    assign bus.ic_req_valid = !reset && (state_q == S_REQ) && (count_q < FULL) && !redirect;
    assign bus.ic_req_addr  = fetch_pc_q;
    assign bus.dec_valid    = head_valid;
    assign bus.dec_pc       = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.dec_instr    = head_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign bus.IFID_npc     = head_valid ? pc_mem_q[rd_ptr_q] + STEP : '0;
    assign bus.halted       = (state_q == S_HALT) && !head_valid;
    assign bus.occupancy    = count_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: an I-cache model plus a queue-based reference of the fetch stream.
// Directed scenarios first, then randomized redirects, backpressure and cache latency.
module tb_fetch_queue_unit;
    localparam int AW    = 64;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    fetch_queue_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .PC_STEP(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // reference model: architectural FIFO contents and the fetch stream
    entry_t        m_fifo[$];
    logic [AW-1:0] m_pc;
    bit            m_out, m_stale, m_halt;

    // I-cache model
    bit            c_pending;
    int            c_cnt;
    logic [AW-1:0] c_addr;
    int            lat_lo = 0, lat_hi = 0;
    bit            zero_at_1004 = 1'b0;
    bit            rand_zeros   = 1'b0;

    // observations
    entry_t        got_q[$];
    logic [AW-1:0] got_npc[$];
    logic [AW-1:0] req_log[$];

    function automatic logic [IW-1:0] prog(input logic [AW-1:0] a);
        if (a == 64'h1000) return 32'h0000_0013;
        if (a == 64'h1004 && zero_at_1004) return '0;
        if (rand_zeros && ((a >> 2) % 13 == 7)) return '0;
        return {a[31:2] ^ 30'h02a5_a5a5, 2'b11};
    endfunction

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit br, input logic [AW-1:0] tgt, input bit rdy, input bit dr);
        bit            exp_req, fire, pop, rv;
        logic [IW-1:0] rd;
        logic [AW-1:0] pc_before;
        entry_t        e;
        @(negedge clk);
        bus.EXIF_branch   = br;
        bus.EXIF_targetpc = tgt;
        bus.ic_req_ready  = rdy;
        bus.dec_ready     = dr;
        rv = c_pending && (c_cnt == 0);
        rd = rv ? prog(c_addr) : IW'($urandom);
        bus.ic_resp_valid = rv;
        bus.ic_resp_data  = rd;
        #1;
        exp_req = !m_halt && !m_out && (m_fifo.size() < DEPTH) && !br;
        check("ic_req_valid", bus.ic_req_valid, exp_req);
        if (exp_req) check("ic_req_addr", bus.ic_req_addr, m_pc);
        check("occupancy", bus.occupancy, m_fifo.size());
        check("dec_valid", bus.dec_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            check("dec_pc", bus.dec_pc, m_fifo[0].pc);
            check("dec_instr", bus.dec_instr, m_fifo[0].instr);
            check("IFID_npc", bus.IFID_npc, m_fifo[0].pc + 64'd4);
        end
        check("halted", bus.halted, m_halt && m_fifo.size() == 0);

        if (bus.dec_valid && dr && !br) begin
            e.pc = bus.dec_pc;
            e.instr = bus.dec_instr;
            got_q.push_back(e);
            got_npc.push_back(bus.IFID_npc);
        end

        fire      = exp_req && rdy;
        pop       = (m_fifo.size() != 0) && dr && !br;
        pc_before = m_pc;
        if (fire) req_log.push_back(m_pc);

        if (br) begin
            m_fifo.delete();
            m_pc   = {tgt[AW-1:2], 2'b00};
            m_halt = 1'b0;
            if (m_out && !rv) m_stale = !m_stale;
            else m_out = 1'b0;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_out && rv) begin
                m_out = 1'b0;
                if (!m_stale) begin
                    if (rd == '0 && HALT_EN) m_halt = 1'b1;
                    else begin
                        e.pc = m_pc;
                        e.instr = rd;
                        m_fifo.push_back(e);
                        m_pc += 64'd4;
                    end
                end
            end
            if (fire) begin
                m_out   = 1'b1;
                m_stale = 1'b0;
            end
        end

        if (rv) c_pending = 1'b0;
        else if (c_pending) c_cnt--;
        if (fire) begin
            c_pending = 1'b1;
            c_cnt     = $urandom_range(lat_hi, lat_lo);
            c_addr    = pc_before;
        end
    endtask

    task automatic do_reset(input logic [AW-1:0] e);
        @(negedge clk);
        reset             = 1'b1;
        bus.entry         = e;
        bus.EXIF_branch   = 1'b0;
        bus.EXIF_targetpc = '0;
        bus.ic_req_ready  = 1'b0;
        bus.dec_ready     = 1'b0;
        bus.ic_resp_valid = 1'b0;
        bus.ic_resp_data  = '0;
        @(negedge clk);
        check("rst_req_valid", bus.ic_req_valid, 1'b0);
        check("rst_req_addr", bus.ic_req_addr, e);
        check("rst_dec_valid", bus.dec_valid, 1'b0);
        check("rst_occupancy", bus.occupancy, 0);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_dec_pc", bus.dec_pc, 0);
        check("rst_dec_instr", bus.dec_instr, 0);
        check("rst_npc", bus.IFID_npc, 0);
        m_fifo.delete();
        m_pc    = e;
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_halt  = 1'b0;
        // a response still owed by the cache arrives right after reset and must be ignored
        if (c_pending) c_cnt = 0;
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        reset             = 1'b1;
        bus.entry         = '0;
        bus.EXIF_branch   = 1'b0;
        bus.EXIF_targetpc = '0;
        bus.ic_req_ready  = 1'b0;
        bus.dec_ready     = 1'b0;
        bus.ic_resp_valid = 1'b0;
        bus.ic_resp_data  = '0;

        // straight-line fetch
        lat_lo = 0; lat_hi = 0;
        do_reset(64'h1000);
        got_q.delete(); got_npc.delete(); req_log.delete();
        repeat (12) step(1'b0, '0, 1'b1, 1'b1);
        check("sl_delivered", got_q.size() >= 3, 1'b1);
        if (got_q.size() >= 3) begin
            check("sl_pc0", got_q[0].pc, 64'h1000);
            check("sl_pc1", got_q[1].pc, 64'h1004);
            check("sl_pc2", got_q[2].pc, 64'h1008);
            check("sl_npc0", got_npc[0], 64'h1004);
            check("sl_npc2", got_npc[2], 64'h100C);
        end
        if (req_log.size() >= 3) begin
            check("sl_req1", req_log[1], 64'h1004);
            check("sl_req2", req_log[2], 64'h1008);
        end

        // backpressure
        do_reset(64'h4000);
        repeat (20) step(1'b0, '0, 1'b1, 1'b0);
        settle();
        check("bp_full_occ", bus.occupancy, 4);
        check("bp_full_req", bus.ic_req_valid, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        settle();
        check("bp_pop_occ", bus.occupancy, 3);
        check("bp_pop_req", bus.ic_req_valid, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        settle();
        check("bp_refill_occ", bus.occupancy, 4);

        // stale response after redirect to an unaligned target
        lat_lo = 2; lat_hi = 2;
        do_reset(64'h1000);
        guard = 0;
        while (!(c_pending && c_addr == 64'h1008) && guard < 60) begin
            step(1'b0, '0, 1'b1, 1'b1);
            guard++;
        end
        check("stale_reach", guard < 60, 1'b1);
        step(1'b1, 64'h2003, 1'b1, 1'b1);
        settle();
        check("stale_flush", bus.occupancy, 0);
        got_q.delete(); got_npc.delete(); req_log.delete();
        repeat (15) step(1'b0, '0, 1'b1, 1'b1);
        check("stale_req_addr", req_log.size() != 0 ? req_log[0] : '1, 64'h2000);
        check("stale_first_pc", got_q.size() != 0 ? got_q[0].pc : '1, 64'h2000);

        // redirect colliding with a response and a pop
        do_reset(64'h4000);
        guard = 0;
        while (!(c_pending && c_cnt == 0 && m_fifo.size() != 0) && guard < 60) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        check("coll_reach", guard < 60, 1'b1);
        step(1'b1, 64'h5000, 1'b0, 1'b1);
        settle();
        check("coll_occ", bus.occupancy, 0);
        check("coll_dec_valid", bus.dec_valid, 1'b0);

        // zero word at 0x1004
        zero_at_1004 = 1'b1;
        lat_lo = 0; lat_hi = 1;
        do_reset(64'h1000);
        got_q.delete(); got_npc.delete(); req_log.delete();
        repeat (20) step(1'b0, '0, 1'b1, 1'b1);
`ifdef FETCH_HALT_ON_ZERO_EN
        check("halt_delivered", got_q.size(), 1);
        check("halt_pc0", got_q.size() != 0 ? got_q[0].pc : '1, 64'h1000);
        check("halt_requests", req_log.size(), 2);
        settle();
        check("halt_halted", bus.halted, 1'b1);
        check("halt_req_valid", bus.ic_req_valid, 1'b0);
`else
        check("zero_delivered", got_q.size() >= 3, 1'b1);
        if (got_q.size() >= 3) begin
            check("zero_pc1", got_q[1].pc, 64'h1004);
            check("zero_instr1", got_q[1].instr, 0);
            check("zero_pc2", got_q[2].pc, 64'h1008);
        end
        settle();
        check("zero_halted", bus.halted, 1'b0);
`endif
        step(1'b1, 64'h3000, 1'b1, 1'b1);
        got_q.delete(); got_npc.delete();
        repeat (10) step(1'b0, '0, 1'b1, 1'b1);
        settle();
        check("resume_halted", bus.halted, 1'b0);
        check("resume_pc", got_q.size() != 0 ? got_q[0].pc : '1, 64'h3000);

        // randomized traffic, including a mid-run reset and PCs near the top of the address space
        zero_at_1004 = 1'b0;
        rand_zeros   = 1'b1;
        lat_lo = 0; lat_hi = 3;
        do_reset(64'h8000);
        for (int i = 0; i < 1500; i++) begin
            bit            br;
            logic [AW-1:0] tgt;
            if (i == 700) do_reset(64'h1_0000);
            br  = ($urandom_range(24, 0) == 0);
            tgt = ($urandom_range(3, 0) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0)))
                                               : {$urandom, $urandom};
            step(br, tgt, $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-slot fetch stage.
- Issues instruction fetches to the I-cache through a valid/ready request and response interface.
- Buffers returned instructions, each with its PC and PC+4, in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake.
- Handles execute-stage redirects with an epoch bit that discards stale in-flight responses, and stops fetching on the all-zero halt word.

Parameters:
- ADDR_WIDTH, 64, width of PC, redirect target and fetch address.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 4, instruction FIFO entries; power of two, at least 2.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- entry  in  ADDR_WIDTH  PC loaded on reset.
- ic_req_valid  out  1  fetch request valid.
- ic_req_addr  out  ADDR_WIDTH  fetch address (current fetch PC).
- ic_req_ready  in  1  I-cache accepts the request.
- ic_resp_valid  in  1  instruction returned (one-cycle pulse).
- ic_resp_data  in  INSTR_WIDTH  returned instruction.
- EXIF_branch  in  1  redirect strobe from execute.
- EXIF_targetpc  in  ADDR_WIDTH  redirect target.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode consumes the head.
- dec_instr  out  INSTR_WIDTH  head instruction.
- dec_pc  out  ADDR_WIDTH  head PC.
- IFID_npc  out  ADDR_WIDTH  head PC + PC_STEP.
- halted  out  1  halt word seen and FIFO drained.
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc=entry, FIFO empty, occupancy=0, epoch=0, state=REQ.
  - Outputs: ic_req_valid=0, dec_valid=0, halted=0; data outputs 0.
  - Reset mid-request abandons the request. A response arriving in the cycle after reset is dropped, because state=REQ.
- At most one request outstanding. FSM states: REQ, WAIT, HALT.
- REQ:
  - ic_req_valid=1 iff occupancy<DEPTH and EXIF_branch=0.
  - Once asserted, ic_req_addr holds stable until ic_req_ready.
  - On valid&&ready: latch req_epoch=epoch, go to WAIT.
- WAIT:
  - On ic_resp_valid with req_epoch==epoch and no redirect that cycle:
    - data!=0: push {fetch_pc, data}, fetch_pc+=PC_STEP, go to REQ.
    - data==0: see Optional Feature.
  - On a mismatched epoch: drop the response and go to REQ; fetch_pc is unchanged (already redirected).
- Redirect (EXIF_branch=1), from any state:
  - fetch_pc = EXIF_targetpc with bits [1:0] forced to 0; epoch toggles; FIFO flushed; halted cleared.
  - Next state: WAIT if a request is still outstanding, otherwise REQ.
  - Redirect wins over a same-cycle response, push or pop: the response is dropped and the pop is discarded.
- FIFO:
  - Space is reserved at request time (occupancy<DEPTH), so a push can never overflow.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
  - dec_* outputs are driven combinationally from the head entry and are valid when occupancy>0.
  - IFID_npc = dec_pc + PC_STEP, modulo 2^ADDR_WIDTH (wraps at max).
- Pop occurs when dec_valid && dec_ready && !EXIF_branch.
- HALT:
  - No requests are issued.
  - halted=1 once occupancy==0 while in HALT.
  - HALT is left only by reset or a redirect.

Optional Feature:
- Macro: FETCH_HALT_ON_ZERO_EN.
- Defined: a non-stale response with data==0 is not pushed; fetch_pc is unchanged; go to HALT.
- Undefined: a zero word is pushed like any other instruction; the HALT state is unreachable and halted stays 0.

Test Plan:
- Straight-line fetch: reset with entry=0x1000, cache always ready, 1-cycle response, dec_ready=1 → decode sees PCs 0x1000, 0x1004, 0x1008 with IFID_npc 0x1004, 0x1008, 0x100C; ic_req_addr increments by 4.
- Backpressure: dec_ready=0, DEPTH=4 → exactly 4 entries accepted, occupancy=4, ic_req_valid=0. Raise dec_ready for one cycle → one pop, then one new request.
- Stale response: redirect to 0x2003 while in WAIT for 0x1008 → that response is dropped and FIFO emptied; next request addr=0x2000; first dec_pc=0x2000.
- Redirect colliding with a response and a pop in the same cycle → response not pushed, FIFO empty, occupancy=0.
- Halt (macro defined): words 0x00000013, 0x00000000 at 0x1000, 0x1004 → only 0x1000 is delivered; halted=1 after it is popped; no further requests. A later redirect to 0x3000 clears halted and fetching resumes.
- Halt (macro undefined): the same program delivers the zero word at 0x1004 with dec_valid=1, and fetch continues at 0x1008.
